// File: rtl/int_div_iterative.sv
// Iterative restoring integer divider: one quotient bit per cycle, signed or unsigned,
// RISC-V divide-by-zero and overflow results, val/rdy request and response interfaces.
module int_div_iterative #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_val,
    output logic         req_rdy,
    input  logic         req_signed,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         resp_val,
    input  logic         resp_rdy,
    output logic [W-1:0] resp_quot,
    output logic [W-1:0] resp_rem
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  dq;      // dividend bits shift out at the MSB while quotient bits shift in at the LSB
    logic [W-1:0]  rem;
    logic [W-1:0]  dvs;
    logic          sign_q;
    logic          sign_r;
    logic          div0;

    logic          req_fire;
    logic          resp_fire;
    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W:0]    rem_sh;
    logic [W:0]    trial;

    assign req_rdy   = (state == IDLE) && !reset;
    assign resp_val  = (state == DONE);
    assign req_fire  = req_val && req_rdy;
    assign resp_fire = resp_val && resp_rdy;

    assign a_neg = req_signed && req_a[W-1];
    assign b_neg = req_signed && req_b[W-1];
    assign a_mag = a_neg ? -req_a : req_a;
    assign b_mag = b_neg ? -req_b : req_b;

    // rem < divisor holds between steps, so W+1 bits are enough and bit W is the borrow
    assign rem_sh = {rem, dq[W-1]};
    assign trial  = rem_sh - {1'b0, dvs};

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            dq     <= '0;
            rem    <= '0;
            dvs    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            div0   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        dq     <= a_mag;
                        dvs    <= b_mag;
                        rem    <= '0;
                        cnt    <= CW'(W);
                        sign_q <= a_neg ^ b_neg;
                        sign_r <= a_neg;
                        div0   <= (req_b == '0);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (trial[W]) begin
                        rem <= rem_sh[W-1:0];
                        dq  <= {dq[W-2:0], 1'b0};
                    end else begin
                        rem <= trial[W-1:0];
                        dq  <= {dq[W-2:0], 1'b1};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (resp_fire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // With a zero divisor every step subtracts nothing, so rem ends as |a| and the
    // remainder negate below restores the original dividend.
    assign resp_quot = div0 ? '1 : (sign_q ? -dq : dq);
    assign resp_rem  = sign_r ? -rem : rem;

endmodule

// File: tb/tb_int_div_iterative.sv
// Randomized scoreboard bench for int_div_iterative: a driver pushes reference-model
// results on each request fire, a monitor pops and compares on each response transfer.
module tb_int_div_iterative;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_val;
    logic         req_rdy;
    logic         req_signed;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         resp_val;
    logic         resp_rdy;
    logic [W-1:0] resp_quot;
    logic [W-1:0] resp_rem;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } resp_t;

    typedef struct packed {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    resp_t exp_q[$];
    int    fire_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    last_fire = 0;
    bit    rand_rdy = 1'b0;
    logic  prev_val = 1'b0;

    int_div_iterative #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_signed (req_signed),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_quot  (resp_quot),
        .resp_rem   (resp_rem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) resp_rdy = (($urandom % 4) != 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain division semantics; zero divisor gives all ones / dividend.
    function automatic resp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        resp_t  res;
        longint sa;
        longint sb;
        if (b == '0) begin
            res.q = '1;
            res.r = a;
        end else if (!s) begin
            res.q = a / b;
            res.r = a % b;
        end else begin
            sa    = longint'($signed(a));
            sb    = longint'($signed(b));
            res.q = W'(sa / sb);
            res.r = W'(sa % sb);
        end
        return res;
    endfunction

    // Monitor: latency on the rising edge of resp_val, data on each response transfer.
    always @(negedge clk) begin : monitor
        resp_t e;
        if (reset) begin
            prev_val = 1'b0;
        end else begin
            if (resp_val && !prev_val) begin
                if (fire_q.size() == 0) check("unexpected_resp_val", resp_val, 0);
                else check("latency", cyc - fire_q[0], W + 1);
            end
            if (resp_val && resp_rdy && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                void'(fire_q.pop_front());
                check("quot", resp_quot, e.q);
                check("rem", resp_rem, e.r);
            end
            prev_val = resp_val;
        end
    end

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        bit got = 1'b0;
        req_val    = 1'b1;
        req_signed = s;
        req_a      = a;
        req_b      = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("req_rdy_timeout", req_rdy, 1);
            req_val = 1'b0;
        end else begin
            exp_q.push_back(model(s, a, b));
            fire_q.push_back(cyc);
            last_fire = cyc;
            @(posedge clk);
            #1;
            if (!hold) begin
                req_val    = 1'b0;
                req_signed = 1'($urandom);
                req_a      = $urandom;
                req_b      = $urandom;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    op_t dir[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  f1;
        bit  seen;
        bit  got;
        op_t o;

        dir = '{
            '{1'b0, 32'd100,        32'd7},
            '{1'b1, 32'hFFFFFFF9,   32'd2},
            '{1'b1, 32'd7,          32'hFFFFFFFE},
            '{1'b0, 32'hFFFFFFF9,   32'd2},
            '{1'b1, 32'hFFFFFFFB,   32'd0},
            '{1'b0, 32'd9,          32'd0},
            '{1'b1, 32'h80000000,   32'hFFFFFFFF},
            '{1'b0, 32'h80000000,   32'hFFFFFFFF}
        };

        reset = 1'b1; req_val = 1'b0; req_signed = 1'b0;
        req_a = '0; req_b = '0; resp_rdy = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_resp_val", resp_val, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_rdy", req_rdy, 1);
        check("post_rst_resp_val", resp_val, 0);
        check("post_rst_quot", resp_quot, 0);
        check("post_rst_rem", resp_rem, 0);
        @(posedge clk);
        #1;

        // Directed corner cases, model-checked by the monitor
        foreach (dir[i]) begin
            issue(dir[i].s, dir[i].a, dir[i].b, 1'b0);
            drain();
        end

        // Backpressure: response must hold while resp_rdy is low
        resp_rdy = 1'b0;
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (resp_val) begin
                got = 1'b1;
                break;
            end
        end
        check("bp_resp_val_seen", got, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_val", resp_val, 1);
            check("bp_hold_quot", resp_quot, 14);
            check("bp_hold_rem", resp_rem, 2);
            check("bp_req_rdy", req_rdy, 0);
        end
        @(posedge clk);
        #1 resp_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_req_rdy", req_rdy, 1);
        check("bp_release_resp_val", resp_val, 0);
        @(posedge clk);
        #1;

        // Back-to-back with req_val held high
        issue(1'b0, 32'd1000, 32'd3, 1'b1);
        f1 = last_fire;
        issue(1'b1, 32'hFFFFFC18, 32'd3, 1'b0);
        check("b2b_spacing", last_fire - f1, W + 2);
        drain();

        // Reset in the middle of CALC discards the operation
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_req_rdy", req_rdy, 0);
        check("midrst_resp_val", resp_val, 0);
        exp_q.delete();
        fire_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_after_req_rdy", req_rdy, 1);
        seen = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            if (resp_val) seen = 1'b1;
        end
        check("aborted_no_resp", seen, 0);
        @(posedge clk);
        #1;
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        drain();

        // Randomized operands with random response backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            o.s = 1'($urandom);
            o.a = $urandom;
            o.b = $urandom;
            case ($urandom_range(0, 5))
                1: o.b = W'($urandom_range(1, 15));
                2: o.b = '0;
                3: begin o.a = 32'h80000000; o.b = '1; end
                4: o.b = -W'($urandom_range(1, 15));
                5: begin o.a = W'($urandom_range(0, 1000)); o.b = $urandom | 32'h40000000; end
                default: ;
            endcase
            issue(o.s, o.a, o.b, (n != 59) && (($urandom % 2) == 1));
        end
        drain();
        @(posedge clk);
        #2;
        rand_rdy = 1'b0;
        resp_rdy = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
